// File: rtl/maindec_pkg.sv
// Shared types and constants for the multicycle LEGv8 main decoder.
// The optional exception/halt logic in maindec_mc is enabled by MAINDEC_EXC_EN.
package maindec_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_CBR      = 4'd9,
        S_UBR      = 4'd10,
        S_ILLEGAL  = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        OC_R, OC_I, OC_LD, OC_ST, OC_CB, OC_B, OC_ILL
    } opclass_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // Masked classes: compare (op & MASK) against the pattern with don't-cares zeroed
    localparam logic [10:0] MASK_I  = 11'b11111111110;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] MASK_CB = 11'b11111110000;
    localparam logic [10:0] OP_CB   = 11'b10110100000;
    localparam logic [10:0] MASK_B  = 11'b11111100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: maps the 11-bit LEGv8 opcode to an opclass_t.
module op_classify
    import maindec_pkg::*;
#(
    parameter int unsigned OP_W = 11
) (
    input  logic [OP_W-1:0] i_op,
    output opclass_t        o_class
);

    always_comb begin
        o_class = OC_ILL;
        if (i_op == OP_ADD || i_op == OP_SUB || i_op == OP_AND || i_op == OP_ORR)
            o_class = OC_R;
        else if ((i_op & MASK_I) == OP_ADDI || (i_op & MASK_I) == OP_SUBI)
            o_class = OC_I;
        else if (i_op == OP_LDUR)
            o_class = OC_LD;
        else if (i_op == OP_STUR)
            o_class = OC_ST;
        else if ((i_op & MASK_CB) == OP_CB)
            o_class = OC_CB;
        else if ((i_op & MASK_B) == OP_B)
            o_class = OC_B;
    end

endmodule

// File: rtl/maindec_mc.sv
// Moore control FSM for the multicycle LEGv8 datapath (FETCH/DECODE/EXEC/MEM/WB).
// Define MAINDEC_EXC_EN for illegal-opcode halt and bounded memory waits.
module maindec_mc
    import maindec_pkg::*;
#(
    parameter int unsigned OP_W        = 11,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    Op,
    input  logic               instr_valid,
    input  logic               dmem_ready,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               Reg2Loc,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               Branch,
    output logic               BranchNZ,
    output logic               Uncond,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Exc,
    output logic [1:0]         ExcCode
);

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] r_op;
    opclass_t        w_class;
    logic            w_mem_wait;

    op_classify #(.OP_W(OP_W)) u_classify (
        .i_op    (r_op),
        .o_class (w_class)
    );

    assign w_mem_wait = (r_state == S_MEM_RD || r_state == S_MEM_WR) && !dmem_ready;

`ifdef MAINDEC_EXC_EN
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_exc_code;
    logic              w_tmo;

    assign w_tmo   = w_mem_wait && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
    assign ExcCode = r_exc_code;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait     <= '0;
            r_exc_code <= EXC_NONE;
        end else begin
            r_wait <= (w_mem_wait && !w_tmo) ? r_wait + 1'b1 : '0;
            if (r_state == S_ILLEGAL)
                r_exc_code <= EXC_ILLEGAL;
            else if (w_tmo)
                r_exc_code <= EXC_TIMEOUT;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^MEM_TIMEOUT;
    assign ExcCode      = '0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (instr_valid) w_next = S_DECODE;
            S_DECODE: begin
                case (w_class)
                    OC_R:        w_next = S_EXEC_R;
                    OC_I:        w_next = S_EXEC_I;
                    OC_LD, OC_ST: w_next = S_MEM_ADDR;
                    OC_CB:       w_next = S_CBR;
                    OC_B:        w_next = S_UBR;
                    default:     w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
            S_MEM_ADDR: w_next = (w_class == OC_ST) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (dmem_ready) w_next = S_MEM_WB;
`ifdef MAINDEC_EXC_EN
                else if (w_tmo) w_next = S_HALT;
`endif
            end
            S_MEM_WR: begin
                if (dmem_ready) w_next = S_FETCH;
`ifdef MAINDEC_EXC_EN
                else if (w_tmo) w_next = S_HALT;
`endif
            end
`ifdef MAINDEC_EXC_EN
            S_ILLEGAL:  w_next = S_HALT;
            S_HALT:     w_next = S_HALT;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && instr_valid)
                r_op <= Op;
        end
    end

    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        BranchNZ = 1'b0;
        Uncond   = 1'b0;
        ALUOp    = ALUOP_W'(ALUOP_ADD);
        Exc      = 1'b0;
        case (r_state)
            // Gated by reset_n so IRWrite stays low while reset holds state at FETCH
            S_FETCH:  IRWrite = instr_valid & reset_n;
            S_EXEC_R: ALUOp = ALUOP_W'(ALUOP_FUNCT);
            S_EXEC_I: begin
                ALUSrc = 1'b1;
                ALUOp  = ALUOP_W'(ALUOP_FUNCT);
            end
            S_ALU_WB: begin
                ALUSrc   = (w_class == OC_I);
                ALUOp    = ALUOP_W'(ALUOP_FUNCT);
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrc  = 1'b1;
                Reg2Loc = (w_class == OC_ST);
            end
            S_MEM_RD: begin
                ALUSrc  = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg = 1'b1;
                MemRead  = 1'b1;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            S_MEM_WR: begin
                Reg2Loc  = 1'b1;
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
                PCWrite  = dmem_ready;
            end
            S_CBR: begin
                Reg2Loc  = 1'b1;
                ALUOp    = ALUOP_W'(ALUOP_PASSB);
                Branch   = 1'b1;
                BranchNZ = r_op[3];
                PCWrite  = 1'b1;
            end
            S_UBR: begin
                Uncond  = 1'b1;
                Branch  = 1'b1;
                PCWrite = 1'b1;
            end
`ifdef MAINDEC_EXC_EN
            S_HALT:    Exc = 1'b1;
`else
            S_ILLEGAL: PCWrite = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/maindec_mc.md
Name: maindec_mc

Overview:
- Multicycle successor to the single-cycle LEGv8 main decoder.
- A Moore-style control FSM sequences each instruction over FETCH/DECODE/EXEC/MEM/WB states, driving the existing datapath control signals plus PC and IR write enables.
- Handshakes with instruction and data memory through valid/ready inputs.
- Sits between the IR/memory interfaces and the datapath in the multicycle processor.

Parameters:
- OP_W, 11, opcode field width (instr[31:21]).
- ALUOP_W, 2, ALUOp width fed to aludec.
- MEM_TIMEOUT, 16, maximum cycles to wait for dmem_ready; used only when MAINDEC_EXC_EN is defined.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- Op  in  OP_W  opcode from instruction bus; sampled only in FETCH.
- instr_valid  in  1  instruction word valid.
- dmem_ready  in  1  data memory completed the access this cycle.
- IRWrite  out  1  latch instruction register.
- PCWrite  out  1  commit PC update; exactly one pulse per retired instruction.
- Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  out  1 each  datapath controls, same meaning as the single-cycle decoder.
- BranchNZ  out  1  CBNZ polarity.
- Uncond  out  1  unconditional branch (B).
- ALUOp  out  ALUOP_W  00 add, 01 pass-B/zero test, 10 funct-decoded.
- Exc  out  1  exception/halt flag (only driven with MAINDEC_EXC_EN, else tied 0).
- ExcCode  out  2  01 illegal opcode, 10 memory timeout, 00 none.

Behaviour:
- Reset (reset_n low, asynchronous): state = FETCH, internal op register = 0, wait counter = 0. Every output is held at 0, including the combinational IRWrite.
- Opcode classes, decoded from the latched op:
  - R: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - I: ADDI 1001000100x, SUBI 1101000100x.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ 10110100xxx, CBNZ 10110101xxx.
  - B 000101xxxxx.
  - Anything else is illegal.
- FETCH:
  - IRWrite = instr_valid. Op is latched when instr_valid=1, then go to DECODE.
  - Otherwise stay in FETCH with all outputs 0.
- DECODE: all outputs 0. Next state by class:
  - R → EXEC_R; I → EXEC_I; LDUR/STUR → MEM_ADDR.
  - CBZ/CBNZ → CBR; B → UBR; illegal → ILLEGAL.
- EXEC_R: ALUOp=10 → ALU_WB.
- EXEC_I: ALUSrc=1, ALUOp=10 → ALU_WB.
- ALU_WB: ALUSrc holds the EXEC_I value; ALUOp=10, RegWrite=1, PCWrite=1 → FETCH.
- MEM_ADDR: ALUSrc=1, ALUOp=00; Reg2Loc=1 for STUR. → MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD:
  - ALUSrc=1, MemRead=1 held until dmem_ready.
  - On dmem_ready → MEM_WB.
- MEM_WB: MemtoReg=1, MemRead=1, RegWrite=1, PCWrite=1 → FETCH.
- MEM_WR:
  - Reg2Loc=1, ALUSrc=1, MemWrite=1 held until dmem_ready.
  - On dmem_ready: PCWrite=1 same cycle → FETCH.
- CBR: Reg2Loc=1, ALUOp=01, Branch=1, BranchNZ=op[3], PCWrite=1 → FETCH. Total 3 cycles.
- UBR: Uncond=1, Branch=1, PCWrite=1 → FETCH.
- ILLEGAL: behaviour per MAINDEC_EXC_EN (below).
- Instruction latencies from the instr_valid cycle:
  - R/I: 4 cycles.
  - LDUR: 5 cycles plus wait cycles.
  - STUR: 4 cycles plus wait cycles.
  - CBZ/CBNZ/B: 3 cycles.
- Boundary conditions:
  - instr_valid is ignored outside FETCH.
  - dmem_ready is ignored outside MEM_RD/MEM_WR.
  - dmem_ready high on the first MEM cycle completes the access with zero wait.
  - Reset mid-instruction aborts with no PCWrite and returns to FETCH.

Optional Feature:
- Macro: MAINDEC_EXC_EN.
- Defined:
  - ILLEGAL → HALT with ExcCode=01.
  - A wait counter increments each MEM_RD/MEM_WR cycle without dmem_ready and clears on leaving the state. When it reaches MEM_TIMEOUT-1 with dmem_ready still low, go to HALT with ExcCode=10; no PCWrite for that instruction.
  - HALT: Exc=1, all other controls 0, sticky until reset.
- Undefined:
  - ILLEGAL acts as NOP: PCWrite=1 → FETCH.
  - Memory waits are unbounded.
  - Exc and ExcCode are tied 0; no counter or HALT logic is synthesised.

Decomposition:
- Package maindec_pkg:
  - state_t enum.
  - opclass_t enum: R, I, LD, ST, CB, B, ILL.
  - Opcode constants and masks.
  - ALUOp constants.
  - ExcCode constants.
- Sub-module op_classify: combinational OP_W → opclass_t, also used by later decoders.

Test Plan:
- ADD 10001011000, instr_valid=1 → IRWrite pulse, then after DECODE and EXEC_R: ALU_WB with RegWrite=1, PCWrite=1 on cycle 4; ALUOp=10 during EXEC_R.
- LDUR 11111000010, dmem_ready low 3 cycles then high → MemRead=1 for 4 cycles, then MEM_WB with MemtoReg=RegWrite=PCWrite=1; total 8 cycles.
- STUR 11111000000, dmem_ready high immediately → MemWrite=1, Reg2Loc=1, PCWrite=1 in the same cycle; 4 cycles total.
- CBNZ 10110101011 → CBR state with Branch=1, BranchNZ=1, ALUOp=01, PCWrite=1; CBZ 10110100000 → same with BranchNZ=0.
- Opcode 11111111111: with MAINDEC_EXC_EN → Exc=1, ExcCode=01 held over 20 cycles, PCWrite never asserts; without → PCWrite=1 and back to FETCH.
- reset_n low during MEM_RD wait → all outputs 0 immediately; after release, FETCH with IRWrite following instr_valid. With MAINDEC_EXC_EN, dmem_ready held low for 16 cycles → ExcCode=10.
